// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: shift-add multiply and
// restoring divide, one bit per cycle, with sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] operandA_i,
  input  logic [WIDTH-1:0] operandB_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] result_o
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q;
  logic [4:0]         cnt_q;
  logic               busy_q, done_q;
  logic               is_div_q, neg_res_q, neg_rem_q, dz_q;
  logic [WIDTH-1:0]   hi_q, lo_q, a_orig_q;
  logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   rem_q;      // divide partial remainder
  logic [2*WIDTH-1:0] acc_q;      // product, or dividend/quotient in low half

  logic               is_md, is_sgn, is_dv;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH:0]     mul_sum, div_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   hi_fix, lo_fix;

  always_comb begin
    is_md  = (funct_i == F_MULT) || (funct_i == F_MULTU) ||
             (funct_i == F_DIV)  || (funct_i == F_DIVU);
    is_sgn = (funct_i == F_MULT) || (funct_i == F_DIV);
    is_dv  = (funct_i == F_DIV)  || (funct_i == F_DIVU);
    a_mag  = (is_sgn && operandA_i[WIDTH-1]) ? -operandA_i : operandA_i;
    b_mag  = (is_sgn && operandB_i[WIDTH-1]) ? -operandB_i : operandB_i;
  end

  // One iteration step: multiplier LSB-first, dividend MSB-first
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {rem_q, acc_q[WIDTH-1]};
    div_ok   = (div_sh >= {1'b0, opnd_q});
    div_diff = div_sh[WIDTH-1:0] - opnd_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    if (is_div_q) begin
      acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ok};
      rem_d = div_ok ? div_diff : div_sh[WIDTH-1:0];
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      hi_fix = neg_rem_q ? -rem_q : rem_q;
      lo_fix = prod_fix[WIDTH-1:0];
      if (dz_q) begin
        hi_fix = a_orig_q;
        lo_fix = '1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      a_orig_q  <= '0;
      opnd_q    <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (is_md) begin
              state_q   <= S_RUN;
              cnt_q     <= '0;
              busy_q    <= 1'b1;
              is_div_q  <= is_dv;
              neg_res_q <= is_sgn && (operandA_i[WIDTH-1] ^ operandB_i[WIDTH-1]);
              neg_rem_q <= is_sgn && operandA_i[WIDTH-1];
              dz_q      <= is_dv && (operandB_i == '0);
              a_orig_q  <= operandA_i;
              rem_q     <= '0;
              opnd_q    <= is_dv ? b_mag : a_mag;
              acc_q     <= {{WIDTH{1'b0}}, (is_dv ? a_mag : b_mag)};
            end else if (funct_i == F_MTHI) begin
              hi_q <= operandA_i;
            end else if (funct_i == F_MTLO) begin
              lo_q <= operandA_i;
            end
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= hi_fix;
          lo_q    <= lo_fix;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
  assign result_o = (funct_i == F_MFHI) ? hi_q :
                    (funct_i == F_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO queued at issue, popped on done.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo, result;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .funct_i(funct),
    .operandA_i(a), .operandB_i(b), .busy_o(busy), .done_o(done),
    .hi_o(hi), .lo_o(lo), .result_o(result)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_pass = 0;
  logic [63:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy, q, r;
    sx = $signed(x); sy = $signed(y);
    ux = {32'h0, x}; uy = {32'h0, y};
    case (f)
      6'h18: return sx * sy;
      6'h19: return ux * uy;
      6'h1A: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        q = sx / sy; r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        q = ux / uy; r = ux % uy;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Drive now, accept on the next edge, then leave funct on MFHI.
  task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y, input bit push);
    start = 1'b1; funct = f; a = x; b = y;
    if (push) sb_q.push_back(model(f, x, y));
    @(posedge clk); #1;
    start = 1'b0; funct = 6'h10;
    check("busy_after_issue", {31'b0, busy}, 32'd1);
    check("done_clr", {31'b0, done}, 32'd0);
  endtask

  // Returns at the negedge of the done cycle; bcyc counts busy cycles seen.
  task automatic wait_done(output int bcyc);
    logic [63:0] e;
    bcyc = 1;  // cycle right after acceptance already checked in issue
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        check("busy_at_done", {31'b0, busy}, 32'd0);
        if (sb_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          check("hi", hi, e[63:32]);
          check("lo", lo, e[31:0]);
          check("mfhi_at_done", result, e[63:32]);
        end
        return;
      end
      if (busy && i > 0) bcyc++;
    end
    check("timeout", {31'b0, done}, 32'd1);
  endtask

  int bc;
  bit saw_done;
  logic [5:0] fl [4] = '{6'h18, 6'h19, 6'h1A, 6'h1B};

  initial begin
    rst = 1'b1; start = 1'b0; funct = 6'h0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);

    issue(6'h18, 32'hFFFFFFFD, 32'd7, 1);
    wait_done(bc);
    check("mult_busy_cycles", bc, 32'd33);
    check("mult_hi_const", hi, 32'hFFFFFFFF);
    check("mult_lo_const", lo, 32'hFFFFFFEB);

    // Back-to-back: issue in the done cycle itself
    issue(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    wait_done(bc);
    check("multu_busy_cycles", bc, 32'd33);
    issue(6'h1A, 32'hFFFFFFF9, 32'd2, 1);
    wait_done(bc);
    check("div_lo_const", lo, 32'hFFFFFFFD);
    issue(6'h1B, 32'd100, 32'd0, 1);
    wait_done(bc);
    check("divu_dz_busy_cycles", bc, 32'd33);
    issue(6'h1A, 32'h80000000, 32'hFFFFFFFF, 1);
    wait_done(bc);
    check("div_ovf_lo", lo, 32'h80000000);
    issue(6'h1A, 32'hFFFFFFFB, 32'd0, 1);
    wait_done(bc);

    // MTHI / MTLO then read next cycle
    start = 1'b1; funct = 6'h11; a = 32'h12345678;
    @(posedge clk); #1;
    funct = 6'h10;
    check("mthi_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("mfhi", result, 32'h12345678);
    start = 1'b1; funct = 6'h13; a = 32'hCAFEF00D;
    @(posedge clk); #1;
    funct = 6'h12;
    check("mtlo_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("mflo", result, 32'hCAFEF00D);
    start = 1'b0;

    // MTLO while busy is ignored
    @(negedge clk);
    issue(6'h18, 32'd5, 32'd6, 1);
    repeat (9) @(posedge clk);
    #1 start = 1'b1; funct = 6'h13; a = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0; funct = 6'h10;
    check("lo_untouched_busy", lo, 32'hCAFEF00D);
    wait_done(bc);

    // Reset mid-flight discards the op
    @(negedge clk);
    issue(6'h1A, 32'd1000, 32'd3, 0);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_hi", hi, 32'h0);
    check("mid_rst_lo", lo, 32'h0);
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    check("no_done_after_rst", {31'b0, saw_done}, 32'd0);
    issue(6'h19, 32'd2, 32'd3, 1);
    wait_done(bc);

    // A few random ops against the model
    for (int k = 0; k < 6; k++) begin
      logic [31:0] rb;
      rb = (k == 5) ? 32'd0 : $urandom;
      @(negedge clk);
      issue(fl[$urandom_range(0, 3)], $urandom, rb, 1);
      wait_done(bc);
      check("rand_busy_cycles", bc, 32'd33);
    end

    check("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit owning the HI/LO register pair. It executes the MIPS MULT, MULTU, DIV and DIVU instructions over multiple cycles, and services MFHI, MFLO, MTHI and MTLO. It sits beside the single-cycle ALU in the execute stage and is launched by the decode controller using the same ALU funct codes. While an operation is in flight it raises `busy`, so the pipeline stalls any further HI/LO instruction.

## Interface
- `WIDTH`, 32, operand and HI/LO register width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  issue strobe; qualifies `funct`/`operandA`/`operandB` this cycle.
- `funct`  in  6  ALU funct code: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
- `operandA`  in  32  rs value (multiplicand, dividend, or MTHI/MTLO source).
- `operandB`  in  32  rt value (multiplier or divisor).
- `busy`  out  1  registered; high while a MULT/DIV is in progress.
- `done`  out  1  registered one-cycle pulse in the first cycle HI/LO hold a new MULT/DIV result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `result`  out  32  combinational: `hi` when `funct`=0x10, `lo` when `funct`=0x12, else 0.

## Operation
- **States:**
  - IDLE.
  - RUN: 32 iterations, counter 0..31.
  - FIX: sign correction and HI/LO write.
- **IDLE acceptance:** with `start`=1 and `busy`=0:
  - MULT/MULTU/DIV/DIVU: latch operands, go to RUN with counter 0.
  - MTHI: `hi`<=`operandA`.
  - MTLO: `lo`<=`operandA`.
  - MFHI/MFLO: no state change; `result` is valid in the same cycle.
  - Any other funct: ignored.
- **Start while busy:** `start`=1 with `busy`=1 is ignored for every funct, including MTHI/MTLO. The controller stalls, so this is an error case only.
- **Signed ops (MULT, DIV):** operate on the magnitudes of the operands.
  - Product and quotient are negated in FIX if the operand signs differ.
  - Remainder takes the sign of the dividend.
- **Unsigned ops (MULTU, DIVU):** operands are used as-is.
- **Multiply:** shift-add, one multiplier bit per RUN cycle, into a 64-bit accumulator. At FIX: `hi`<=product[63:32], `lo`<=product[31:0].
- **Divide:** restoring algorithm, one quotient bit per RUN cycle, with a 33-bit partial remainder. At FIX: `lo`<=quotient, `hi`<=remainder.
- **Divide by zero** (`operandB`=0, DIV or DIVU):
  - Still takes the full latency.
  - Result is fixed: `lo`<=0xFFFFFFFF, `hi`<=`operandA` (original signed value, unmodified).
- **DIV 0x80000000 / 0xFFFFFFFF:** `lo`=0x80000000, `hi`=0. This is the natural wrap; no trap.
- **RUN/FIX transitions:** RUN stays for exactly 32 cycles, then goes to FIX. FIX always goes to IDLE after one cycle.
- **HI/LO writes:** HI/LO change only at an MTHI/MTLO acceptance, at the FIX edge, or on reset.

## Timing
- **Reset:** on any `rst`=1 edge, in any state:
  - state<=IDLE, counter<=0.
  - `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - An in-flight operation is discarded and no partial result is written.
- **MULT/DIV accepted at edge E0:**
  - `busy`=1 from E0 through the cycle ending at edge E33 (33 cycles: 32 RUN + 1 FIX).
  - `hi`/`lo` are updated at E33.
  - At E33: `busy`<=0, `done`<=1.
  - At E34: `done`<=0.
- **Back-to-back issue:** a new MULT/DIV may be accepted in the first cycle with `busy`=0, i.e. the edge after E33. Minimum issue interval is 34 cycles.
- **MTHI/MTLO:** 1-cycle latency, no `busy` assertion. A following MFHI/MFLO in the next cycle sees the new value.
- **MFHI/MFLO read timing:**
  - MFHI/MFLO in the same cycle as the `done` pulse returns the new result.
  - During `busy`, `result` shows the stale HI/LO; the controller must stall.
- **`rst` and `start` together:** `rst` wins; `start` is ignored.

## Test plan
- After reset: MULT with `operandA`=0xFFFFFFFD (-3), `operandB`=7 -> `busy` high exactly 33 cycles, then `done` pulses once with `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. Then DIV 0xFFFFFFF9 (-7) / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 100 / 0 -> after 33 busy cycles, `lo`=0xFFFFFFFF, `hi`=100. DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- MTHI 0x12345678, next cycle MFHI -> `result`=0x12345678 with `busy` never asserted. MTLO 0xCAFEF00D then MFLO -> `result`=0xCAFEF00D.
- Start MULT 5 x 6, then at busy cycle 10 pulse `start` with MTLO 0xDEADBEEF -> ignored; final `lo`=30, `hi`=0.
- Start DIV 1000 / 3, assert `rst` at busy cycle 20 -> next cycle `busy`=0, `hi`=`lo`=0, no `done` pulse. A new MULTU 2 x 3 completes normally with `lo`=6.
